// File: rtl/dds_sweep_ctrl.sv
// DDS configuration/sequencing controller: shadow registers behind a valid/ready
// command port, driving Fword/Pword/Mode_Sel statically or as a linear frequency sweep.
module dds_sweep_ctrl #(
  parameter int DWELL_W = 24
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Cmd_Valid,
  output logic         Cmd_Ready,
  input  logic [2:0]   Cmd_Addr,
  input  logic [31:0]  Cmd_Data,
  output logic [31:0]  Fword,
  output logic [11:0]  Pword,
  output logic [1:0]   Mode_Sel,
  output logic         Sweep_Busy,
  output logic         Sweep_Done
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t              state_q;
  logic                ready_q;
  logic [1:0]          mode_q;
  logic [31:0]         fstart_q;
  logic [11:0]         pword_sh_q;
  logic [31:0]         fstop_q;
  logic [31:0]         fstep_q;
  logic [DWELL_W-1:0]  dwell_q;
  logic [DWELL_W-1:0]  cnt_q;
  logic [31:0]         fword_q;
  logic [11:0]         pword_q;
  logic [1:0]          mode_sel_q;
  logic                busy_q;
  logic                done_q;

  logic                cmd_fire;
  logic                ctrl_fire;
  logic                do_commit;
  logic                do_start;
  logic                do_abort;
  logic [32:0]         step_sum_d;
  logic [DWELL_W-1:0]  dwell_reload_d;
  logic                sweep_empty_d;

  assign cmd_fire  = Cmd_Valid & ready_q;
  assign ctrl_fire = cmd_fire & (Cmd_Addr == 3'd6);
  assign do_abort  = ctrl_fire & Cmd_Data[2];
  assign do_start  = ctrl_fire & Cmd_Data[1];
  assign do_commit = ctrl_fire & Cmd_Data[0];

  // 33-bit sum so a wrap past 2^32 clamps to FSTOP instead of restarting low
  assign step_sum_d     = {1'b0, fword_q} + {1'b0, fstep_q};
  assign dwell_reload_d = (dwell_q == '0) ? DWELL_ONE : dwell_q;
  assign sweep_empty_d  = (fstep_q == 32'd0) || (fstop_q <= fstart_q);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ready_q    <= 1'b0;
      mode_q     <= '0;
      fstart_q   <= '0;
      pword_sh_q <= '0;
      fstop_q    <= '0;
      fstep_q    <= '0;
      dwell_q    <= '0;
    end else begin
      ready_q <= 1'b1;
      if (cmd_fire) begin
        case (Cmd_Addr)
          3'd0:    mode_q     <= Cmd_Data[1:0];
          3'd1:    fstart_q   <= Cmd_Data;
          3'd2:    pword_sh_q <= Cmd_Data[11:0];
          3'd3:    fstop_q    <= Cmd_Data;
          3'd4:    fstep_q    <= Cmd_Data;
          3'd5:    dwell_q    <= Cmd_Data[DWELL_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fword_q    <= '0;
      pword_q    <= '0;
      mode_sel_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (do_abort) begin
            state_q <= IDLE;
          end else if (do_start) begin
            fword_q    <= fstart_q;
            pword_q    <= pword_sh_q;
            mode_sel_q <= mode_q;
            if (sweep_empty_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SWEEP;
              busy_q  <= 1'b1;
              cnt_q   <= dwell_reload_d;
            end
          end else if (do_commit) begin
            fword_q    <= fstart_q;
            pword_q    <= pword_sh_q;
            mode_sel_q <= mode_q;
          end
        end
        SWEEP: begin
          if (do_abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q <= DWELL_ONE) begin
            if (step_sum_d >= {1'b0, fstop_q}) begin
              fword_q <= fstop_q;
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              fword_q <= step_sum_d[31:0];
              cnt_q   <= dwell_reload_d;
            end
          end else begin
            cnt_q <= cnt_q - DWELL_ONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Cmd_Ready  = ready_q;
  assign Fword      = fword_q;
  assign Pword      = pword_q;
  assign Mode_Sel   = mode_sel_q;
  assign Sweep_Busy = busy_q;
  assign Sweep_Done = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: table of static register/commit vectors plus
// hand-sequenced sweep, carry clamp, abort, degenerate start and async reset cases.
module tb_dds_sweep_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Cmd_Valid = 1'b0;
  logic        Cmd_Ready;
  logic [2:0]  Cmd_Addr = '0;
  logic [31:0] Cmd_Data = '0;
  logic [31:0] Fword;
  logic [11:0] Pword;
  logic [1:0]  Mode_Sel;
  logic        Sweep_Busy;
  logic        Sweep_Done;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  dds_sweep_ctrl #(.DWELL_W(24)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Cmd_Addr(Cmd_Addr), .Cmd_Data(Cmd_Data), .Fword(Fword), .Pword(Pword),
    .Mode_Sel(Mode_Sel), .Sweep_Busy(Sweep_Busy), .Sweep_Done(Sweep_Done)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] f;
    logic [11:0] p;
    logic [1:0]  m;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Drive one command beat; returns #1 after the edge that follows the handshake.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    Cmd_Valid = 1'b1;
    Cmd_Addr  = a;
    Cmd_Data  = d;
    @(posedge Clk);
    #1;
    Cmd_Valid = 1'b0;
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_0001, 32'h0000_0000, 12'h000, 2'd0};
    vecs[1]  = '{3'd1, 32'h0010_0000, 32'h0000_0000, 12'h000, 2'd0};
    vecs[2]  = '{3'd2, 32'h0000_0400, 32'h0000_0000, 12'h000, 2'd0};
    vecs[3]  = '{3'd6, 32'h0000_0001, 32'h0010_0000, 12'h400, 2'd1};
    vecs[4]  = '{3'd0, 32'h0000_0002, 32'h0010_0000, 12'h400, 2'd1};
    vecs[5]  = '{3'd7, 32'hFFFF_FFFF, 32'h0010_0000, 12'h400, 2'd1};
    vecs[6]  = '{3'd6, 32'h0000_0007, 32'h0010_0000, 12'h400, 2'd1};
    vecs[7]  = '{3'd1, 32'h1234_5678, 32'h0010_0000, 12'h400, 2'd1};
    vecs[8]  = '{3'd2, 32'h0000_1ABC, 32'h0010_0000, 12'h400, 2'd1};
    vecs[9]  = '{3'd6, 32'h0000_0001, 32'h1234_5678, 12'hABC, 2'd2};
    vecs[10] = '{3'd6, 32'h0000_0000, 32'h1234_5678, 12'hABC, 2'd2};

    // Reset state
    #12;
    chk("rst_ready", {31'd0, Cmd_Ready}, 32'd0);
    chk("rst_fword", Fword, 32'd0);
    chk("rst_pword", {20'd0, Pword}, 32'd0);
    chk("rst_mode", {30'd0, Mode_Sel}, 32'd0);
    chk("rst_busy", {31'd0, Sweep_Busy}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    chk("ready_after_rst", {31'd0, Cmd_Ready}, 32'd1);

    // Static shadow writes and commits
    for (int i = 0; i < 11; i++) begin
      wr(vecs[i].addr, vecs[i].data);
      $display("vec %0d addr=%0d data=0x%08h -> F=0x%08h P=0x%03h M=%0d", i, vecs[i].addr,
               vecs[i].data, Fword, Pword, Mode_Sel);
      chk($sformatf("vec%0d_fword", i), Fword, vecs[i].f);
      chk($sformatf("vec%0d_pword", i), {20'd0, Pword}, {20'd0, vecs[i].p});
      chk($sformatf("vec%0d_mode", i), {30'd0, Mode_Sel}, {30'd0, vecs[i].m});
      chk($sformatf("vec%0d_busy", i), {31'd0, Sweep_Busy}, 32'd0);
      chk($sformatf("vec%0d_done", i), {31'd0, Sweep_Done}, 32'd0);
    end

    // Linear sweep 100 -> 130, step 10, dwell 3
    wr(3'd1, 32'd100); wr(3'd3, 32'd130); wr(3'd4, 32'd10); wr(3'd5, 32'd3);
    wr(3'd6, 32'd2);
    for (int k = 0; k <= 10; k++) begin
      logic [31:0] ef;
      logic eb, ed;
      ef = (k < 9) ? 32'd100 + 32'd10 * (k / 3) : 32'd130;
      eb = (k < 9);
      ed = (k == 9);
      $display("sweep k=%0d F=%0d busy=%0b done=%0b", k, Fword, Sweep_Busy, Sweep_Done);
      chk($sformatf("sweep_f%0d", k), Fword, ef);
      chk($sformatf("sweep_b%0d", k), {31'd0, Sweep_Busy}, {31'd0, eb});
      chk($sformatf("sweep_d%0d", k), {31'd0, Sweep_Done}, {31'd0, ed});
      tick();
    end

    // Carry clamp: 0xFFFFFFF0 + 0x20 overflows 32 bits
    wr(3'd1, 32'hFFFF_FFF0); wr(3'd3, 32'hFFFF_FFFF); wr(3'd4, 32'h20); wr(3'd5, 32'd0);
    wr(3'd6, 32'd2);
    $display("carry start F=0x%08h busy=%0b", Fword, Sweep_Busy);
    chk("carry_f0", Fword, 32'hFFFF_FFF0);
    chk("carry_b0", {31'd0, Sweep_Busy}, 32'd1);
    tick();
    $display("carry step F=0x%08h done=%0b", Fword, Sweep_Done);
    chk("carry_f1", Fword, 32'hFFFF_FFFF);
    chk("carry_d1", {31'd0, Sweep_Done}, 32'd1);
    chk("carry_b1", {31'd0, Sweep_Busy}, 32'd0);
    tick();
    chk("carry_d2", {31'd0, Sweep_Done}, 32'd0);

    // Abort mid-sweep at FSTART+4
    wr(3'd1, 32'd200); wr(3'd3, 32'd1000); wr(3'd4, 32'd1); wr(3'd5, 32'd5);
    wr(3'd6, 32'd2);
    begin
      int n;
      n = 0;
      while (Fword !== 32'd204 && n < 60) begin
        tick();
        n++;
      end
      chk("abort_reach", Fword, 32'd204);
    end
    wr(3'd6, 32'd4);
    $display("abort F=%0d busy=%0b done=%0b", Fword, Sweep_Busy, Sweep_Done);
    chk("abort_f", Fword, 32'd204);
    chk("abort_busy", {31'd0, Sweep_Busy}, 32'd0);
    begin
      int dcount;
      dcount = 0;
      for (int k = 0; k < 8; k++) begin
        if (Sweep_Done === 1'b1) dcount++;
        tick();
      end
      chk("abort_no_done", dcount, 0);
      chk("abort_hold", Fword, 32'd204);
    end
    wr(3'd6, 32'd1);
    $display("commit after abort F=%0d", Fword);
    chk("abort_commit", Fword, 32'd200);

    // Degenerate start: FSTOP == FSTART
    wr(3'd1, 32'd50); wr(3'd3, 32'd50); wr(3'd4, 32'd10);
    wr(3'd6, 32'd2);
    $display("degenerate F=%0d busy=%0b done=%0b", Fword, Sweep_Busy, Sweep_Done);
    chk("degen_f", Fword, 32'd50);
    chk("degen_done", {31'd0, Sweep_Done}, 32'd1);
    chk("degen_busy", {31'd0, Sweep_Busy}, 32'd0);
    tick();
    chk("degen_done_clr", {31'd0, Sweep_Done}, 32'd0);
    chk("degen_busy1", {31'd0, Sweep_Busy}, 32'd0);

    // Async reset mid-sweep, then a fresh sweep from cleared shadows
    wr(3'd1, 32'd100); wr(3'd3, 32'd130); wr(3'd4, 32'd10); wr(3'd5, 32'd3);
    wr(3'd6, 32'd2);
    tick();
    #2;
    Reset_n = 1'b0;
    #1;
    $display("async reset F=%0d busy=%0b ready=%0b", Fword, Sweep_Busy, Cmd_Ready);
    chk("arst_f", Fword, 32'd0);
    chk("arst_busy", {31'd0, Sweep_Busy}, 32'd0);
    chk("arst_ready", {31'd0, Cmd_Ready}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    chk("arst_ready1", {31'd0, Cmd_Ready}, 32'd1);
    chk("arst_nodone", {31'd0, Sweep_Done}, 32'd0);
    wr(3'd1, 32'd10); wr(3'd3, 32'd20); wr(3'd4, 32'd5); wr(3'd5, 32'd1);
    wr(3'd6, 32'd2);
    for (int k = 0; k <= 3; k++) begin
      logic [31:0] ef;
      ef = (k >= 2) ? 32'd20 : 32'd10 + 32'd5 * k;
      $display("post-reset sweep k=%0d F=%0d done=%0b", k, Fword, Sweep_Done);
      chk($sformatf("rsweep_f%0d", k), Fword, ef);
      chk($sformatf("rsweep_d%0d", k), {31'd0, Sweep_Done}, {31'd0, (k == 2)});
      chk($sformatf("rsweep_b%0d", k), {31'd0, Sweep_Busy}, {31'd0, (k < 2)});
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
